// File: rtl/recovery_pkg.sv
// Shared types and constants for the bit-clock recovery lock controller and estimator.
// State encoding is visible on the controller's state output, so values are fixed.
package recovery_pkg;
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ACQUIRE = 2'd1,
        ST_LOCKED  = 2'd2,
        ST_LOST    = 2'd3
    } rec_state_t;

    localparam int PERIOD_W_DEF = 16;

    // Estimator control polarity: est_clear reloads the initial period, est_hold freezes updates.
    localparam logic EST_CLEAR_PULSE = 1'b1;
    localparam logic EST_CLEAR_IDLE  = 1'b0;
    localparam logic EST_HOLD_FREEZE = 1'b1;
    localparam logic EST_HOLD_TRACK  = 1'b0;
endpackage

// File: rtl/rec_watchdog.sv
// Edge-activity watchdog: counts cycles since the last edge, pulses timeout at TIMEOUT-1
// and restarts, so a persistent silence produces one pulse every TIMEOUT cycles.
module rec_watchdog #(
    parameter int TIMEOUT = 4096
) (
    input  logic clk_200M,
    input  logic rst,
    input  logic clr,
    input  logic edge_det,
    output logic timeout
);
    localparam int            CW   = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] TC   = CW'(TIMEOUT - 1);
    localparam logic [CW-1:0] CMAX = {CW{1'b1}};

    logic [CW-1:0] idle_cnt_q, idle_cnt_d;

    // An edge in the terminal cycle wins: the counter clears and no pulse is issued.
    assign timeout = !clr && !edge_det && (idle_cnt_q == TC);

    always_comb begin
        idle_cnt_d = idle_cnt_q;
        if (clr || edge_det || timeout) begin
            idle_cnt_d = '0;
        end else if (idle_cnt_q != CMAX) begin
            idle_cnt_d = idle_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_200M) begin
        if (rst) begin
            idle_cnt_q <= '0;
        end else begin
            idle_cnt_q <= idle_cnt_d;
        end
    end
endmodule

// File: rtl/recovery_lock_ctrl.sv
// Lock/acquisition sequencer for the minimum-interval period estimator; all outputs registered.
// Optional LOCK_STATS_EN adds a saturating relock_count output (reset by rst only).
module recovery_lock_ctrl
    import recovery_pkg::*;
#(
    parameter int PERIOD_W     = PERIOD_W_DEF,
    parameter int ACQ_EDGES    = 16,
    parameter int TOL          = 2,
    parameter int MAX_RUN_LOG2 = 3,
    parameter int ERR_LIMIT    = 4,
    parameter int TIMEOUT      = 4096
) (
    input  logic                clk_200M,
    input  logic                rst,
    input  logic                enable,
    input  logic                edge_det,
    input  logic [PERIOD_W-1:0] interval_in,
    input  logic [PERIOD_W-1:0] period_in,
    output logic                est_clear,
    output logic                est_hold,
    output logic                locked,
    output logic                lock_lost,
    output logic [PERIOD_W-1:0] period_lock,
    output logic [1:0]          state
`ifdef LOCK_STATS_EN
    ,
    output logic [7:0]          relock_count
`endif
);
    localparam int            SC_W   = $clog2(ACQ_EDGES + 1);
    localparam logic [SC_W-1:0] SC_MAX = SC_W'(ACQ_EDGES - 1);
    localparam int            EC_W   = $clog2(ERR_LIMIT + 1);
    localparam logic [EC_W-1:0] EC_LIM = EC_W'(ERR_LIMIT);
    localparam int            HI_W   = PERIOD_W + MAX_RUN_LOG2;

    rec_state_t            state_q;
    logic                  est_clear_q, est_hold_q, locked_q, lock_lost_q;
    logic [PERIOD_W-1:0]   period_lock_q, last_period_q;
    logic [SC_W-1:0]       stable_cnt_q;
    logic [EC_W-1:0]       err_cnt_q;

    logic                  wd_clr, wd_timeout;
    logic [SC_W-1:0]       stable_d;
    logic [EC_W-1:0]       err_inc, err_dec;
    logic [PERIOD_W-1:0]   lo_bound;
    logic [HI_W-1:0]       hi_bound;
    logic                  bad_edge;

    assign wd_clr = !enable || (state_q == ST_IDLE) || (state_q == ST_LOST);

    rec_watchdog #(.TIMEOUT(TIMEOUT)) u_wd (
        .clk_200M (clk_200M),
        .rst      (rst),
        .clr      (wd_clr),
        .edge_det (edge_det),
        .timeout  (wd_timeout)
    );

    assign stable_d = (period_in != last_period_q) ? '0 :
                      (stable_cnt_q == SC_MAX)     ? stable_cnt_q : stable_cnt_q + 1'b1;

    // Lower bound floors at zero; upper bound is widened so the shift never truncates.
    assign lo_bound = (period_lock_q >= PERIOD_W'(TOL)) ? period_lock_q - PERIOD_W'(TOL) : '0;
    assign hi_bound = {period_lock_q, {MAX_RUN_LOG2{1'b0}}};
    assign bad_edge = (interval_in < lo_bound) ||
                      ({{MAX_RUN_LOG2{1'b0}}, interval_in} > hi_bound);
    assign err_inc  = err_cnt_q + 1'b1;
    assign err_dec  = (err_cnt_q == '0) ? '0 : err_cnt_q - 1'b1;

    always_ff @(posedge clk_200M) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            est_clear_q   <= EST_CLEAR_IDLE;
            est_hold_q    <= EST_HOLD_TRACK;
            locked_q      <= 1'b0;
            lock_lost_q   <= 1'b0;
            period_lock_q <= '0;
            last_period_q <= '0;
            stable_cnt_q  <= '0;
            err_cnt_q     <= '0;
        end else begin
            est_clear_q <= EST_CLEAR_IDLE;
            lock_lost_q <= 1'b0;
            if (!enable) begin
                state_q      <= ST_IDLE;
                est_hold_q   <= EST_HOLD_TRACK;
                locked_q     <= 1'b0;
                stable_cnt_q <= '0;
                err_cnt_q    <= '0;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        state_q      <= ST_ACQUIRE;
                        est_clear_q  <= EST_CLEAR_PULSE;
                        stable_cnt_q <= '0;
                    end
                    ST_ACQUIRE: begin
                        if (wd_timeout) begin
                            est_clear_q  <= EST_CLEAR_PULSE;
                            stable_cnt_q <= '0;
                        end else if (edge_det) begin
                            last_period_q <= period_in;
                            stable_cnt_q  <= stable_d;
                            if (stable_d == SC_MAX) begin
                                period_lock_q <= period_in;
                                state_q       <= ST_LOCKED;
                                locked_q      <= 1'b1;
                                est_hold_q    <= EST_HOLD_FREEZE;
                                err_cnt_q     <= '0;
                            end
                        end
                    end
                    ST_LOCKED: begin
                        if (wd_timeout || (edge_det && bad_edge && err_inc == EC_LIM)) begin
                            state_q     <= ST_LOST;
                            lock_lost_q <= 1'b1;
                            locked_q    <= 1'b0;
                            est_hold_q  <= EST_HOLD_TRACK;
                        end else if (edge_det) begin
                            err_cnt_q <= bad_edge ? err_inc : err_dec;
                        end
                    end
                    default: begin
                        state_q      <= ST_ACQUIRE;
                        est_clear_q  <= EST_CLEAR_PULSE;
                        stable_cnt_q <= '0;
                        err_cnt_q    <= '0;
                    end
                endcase
            end
        end
    end

`ifdef LOCK_STATS_EN
    logic [7:0] relock_count_q;
    // lock_lost_q is high exactly once per LOST entry, so it doubles as the count strobe.
    always_ff @(posedge clk_200M) begin
        if (rst) begin
            relock_count_q <= '0;
        end else if (lock_lost_q && relock_count_q != 8'hFF) begin
            relock_count_q <= relock_count_q + 8'd1;
        end
    end
    assign relock_count = relock_count_q;
`endif

    assign est_clear   = est_clear_q;
    assign est_hold    = est_hold_q;
    assign locked      = locked_q;
    assign lock_lost   = lock_lost_q;
    assign period_lock = period_lock_q;
    assign state       = state_q;
endmodule

// File: tb/tb_recovery_lock_ctrl.sv
// Directed bench for recovery_lock_ctrl; define LOCK_STATS_EN to also check relock_count.
module tb_recovery_lock_ctrl;
    logic        clk_200M = 1'b0;
    logic        rst = 1'b1;
    logic        enable = 1'b0;
    logic        edge_det = 1'b0;
    logic [15:0] interval_in = '0;
    logic [15:0] period_in = '0;
    logic        est_clear, est_hold, locked, lock_lost;
    logic [15:0] period_lock;
    logic [1:0]  state;
`ifdef LOCK_STATS_EN
    logic [7:0]  relock_count;
`endif
    int total = 0;
    int bad = 0;

    always #2.5 clk_200M = ~clk_200M;

    recovery_lock_ctrl dut (
        .clk_200M    (clk_200M),
        .rst         (rst),
        .enable      (enable),
        .edge_det    (edge_det),
        .interval_in (interval_in),
        .period_in   (period_in),
        .est_clear   (est_clear),
        .est_hold    (est_hold),
        .locked      (locked),
        .lock_lost   (lock_lost),
        .period_lock (period_lock),
        .state       (state)
`ifdef LOCK_STATS_EN
        ,
        .relock_count(relock_count)
`endif
    );

    // Inputs change and outputs are sampled 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk_200M);
        #1;
    endtask

    task automatic do_edge(input int iv, input int pv);
        edge_det    = 1'b1;
        interval_in = 16'(iv);
        period_in   = 16'(pv);
        tick();
        edge_det = 1'b0;
    endtask

    task automatic gap(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic relock();
        int n = 0;
        while (!locked && n < 40) begin
            gap(9);
            do_edge(50, 50);
            n++;
        end
        total++;
        if (locked !== 1'b1) begin
            bad++; $display("FAIL relock: locked=%b after %0d edges, want 1", locked, n);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; enable = 1'b0;
        gap(3);
        total += 6;
        if (state !== 2'd0)       begin bad++; $display("FAIL reset_state: got %0d want 0", state); end
        if (est_clear !== 1'b0)   begin bad++; $display("FAIL reset_est_clear: got %b want 0", est_clear); end
        if (est_hold !== 1'b0)    begin bad++; $display("FAIL reset_est_hold: got %b want 0", est_hold); end
        if (locked !== 1'b0)      begin bad++; $display("FAIL reset_locked: got %b want 0", locked); end
        if (lock_lost !== 1'b0)   begin bad++; $display("FAIL reset_lock_lost: got %b want 0", lock_lost); end
        if (period_lock !== 16'd0) begin bad++; $display("FAIL reset_period_lock: got %0d want 0", period_lock); end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_acquire();
        int clears = 0;
        int early = 0;
        enable = 1'b1;
        tick();
        total += 2;
        if (state !== 2'd1)     begin bad++; $display("FAIL acq_enter: state=%0d want 1", state); end
        if (est_clear !== 1'b1) begin bad++; $display("FAIL acq_clear: est_clear=%b want 1", est_clear); end
        for (int i = 1; i <= 16; i++) begin
            for (int g = 0; g < 49; g++) begin tick(); if (est_clear) clears++; end
            do_edge(50, 50);
            if (est_clear) clears++;
            if (i < 16 && locked) early++;
        end
        total += 5;
        if (clears != 0)          begin bad++; $display("FAIL acq_extra_clear: got %0d want 0", clears); end
        if (early != 0)           begin bad++; $display("FAIL acq_early_lock: got %0d want 0", early); end
        if (locked !== 1'b1)      begin bad++; $display("FAIL acq_locked: got %b want 1", locked); end
        if (period_lock !== 16'd50) begin bad++; $display("FAIL acq_period: got %0d want 50", period_lock); end
        if (est_hold !== 1'b1 || state !== 2'd2) begin
            bad++; $display("FAIL acq_hold_state: hold=%b state=%0d want 1/2", est_hold, state);
        end
    endtask

    task automatic test_unstable();
        int lock_edge = 0;
        enable = 1'b0;
        tick();
        total += 2;
        if (state !== 2'd0 || locked !== 1'b0) begin
            bad++; $display("FAIL ctrl_disable: state=%0d locked=%b want 0/0", state, locked);
        end
        if (lock_lost !== 1'b0) begin bad++; $display("FAIL ctrl_no_lost: got %b want 0", lock_lost); end
        enable = 1'b1;
        tick();
        for (int i = 1; i <= 30 && lock_edge == 0; i++) begin
            gap(9);
            do_edge(50, (i < 10) ? 60 : 50);
            if (locked) lock_edge = i;
        end
        total++;
        if (lock_edge != 25) begin bad++; $display("FAIL unstable_lock_edge: got %0d want 25", lock_edge); end
    endtask

    task automatic test_error_loss();
        for (int i = 1; i <= 4; i++) begin
            gap(9);
            do_edge(40, 50);
            if (i == 3) begin
                total++;
                if (locked !== 1'b1) begin bad++; $display("FAIL err_3rd_locked: got %b want 1", locked); end
            end
        end
        total += 2;
        if (lock_lost !== 1'b1 || locked !== 1'b0) begin
            bad++; $display("FAIL err_lost: lock_lost=%b locked=%b want 1/0", lock_lost, locked);
        end
        if (state !== 2'd3 || est_hold !== 1'b0) begin
            bad++; $display("FAIL err_lost_state: state=%0d hold=%b want 3/0", state, est_hold);
        end
        tick();
        total++;
        if (est_clear !== 1'b1 || state !== 2'd1 || lock_lost !== 1'b0) begin
            bad++; $display("FAIL err_reacq: clear=%b state=%0d lost=%b want 1/1/0", est_clear, state, lock_lost);
        end
    endtask

    task automatic test_leaky();
        int drops = 0;
        int seq_hi[6] = '{401, 401, 401, 400, 401, 401};
        int seq_lo[6] = '{47, 47, 47, 48, 47, 47};
        relock();
        for (int i = 0; i < 100; i++) begin
            gap(9);
            do_edge((i % 2 == 0) ? 40 : 50, 50);
            if (!locked) drops++;
        end
        total++;
        if (drops != 0) begin bad++; $display("FAIL leaky_hold: drops=%0d want 0", drops); end
        for (int i = 0; i < 6; i++) begin
            gap(9);
            do_edge(seq_hi[i], 50);
            if (i == 4) begin
                total++;
                if (locked !== 1'b1) begin bad++; $display("FAIL leaky_400_good: locked=%b want 1", locked); end
            end
        end
        total++;
        if (lock_lost !== 1'b1) begin bad++; $display("FAIL leaky_401_bad: lock_lost=%b want 1", lock_lost); end
        tick();
        relock();
        for (int i = 0; i < 6; i++) begin
            gap(9);
            do_edge(seq_lo[i], 50);
            if (i == 4) begin
                total++;
                if (locked !== 1'b1) begin bad++; $display("FAIL leaky_48_good: locked=%b want 1", locked); end
            end
        end
        total++;
        if (lock_lost !== 1'b1) begin bad++; $display("FAIL leaky_47_bad: lock_lost=%b want 1", lock_lost); end
        tick();
`ifdef LOCK_STATS_EN
        total++;
        if (relock_count !== 8'd3) begin bad++; $display("FAIL stats_three: got %0d want 3", relock_count); end
`endif
    endtask

    task automatic test_timeout();
        int k = 0;
        int lost_seen = 0;
        relock();
        while (!lock_lost && k < 5000) begin tick(); k++; end
        total++;
        if (k != 4096) begin bad++; $display("FAIL to_locked_delay: got %0d cycles want 4096", k); end
        tick();
        for (int r = 0; r < 2; r++) begin
            k = 0;
            tick(); k++;
            while (!est_clear && k < 5000) begin if (lock_lost) lost_seen++; tick(); k++; end
            total++;
            if (k != 4096) begin bad++; $display("FAIL to_acq_period%0d: got %0d want 4096", r, k); end
        end
        // Edge lands in the terminal cycle, so no clear may follow.
        gap(4095);
        do_edge(50, 50);
        total += 2;
        if (est_clear !== 1'b0) begin bad++; $display("FAIL to_edge_priority: est_clear=%b want 0", est_clear); end
        if (lost_seen != 0 || state !== 2'd1) begin
            bad++; $display("FAIL to_acq_no_lost: lost=%0d state=%0d want 0/1", lost_seen, state);
        end
    endtask

    task automatic test_control();
        relock();
        enable = 1'b0;
        tick();
        total++;
        if (state !== 2'd0 || locked !== 1'b0 || est_hold !== 1'b0 || lock_lost !== 1'b0) begin
            bad++; $display("FAIL ctrl_drop_locked: state=%0d locked=%b hold=%b lost=%b want 0/0/0/0",
                            state, locked, est_hold, lock_lost);
        end
        total++;
        if (period_lock !== 16'd50) begin bad++; $display("FAIL ctrl_period_held: got %0d want 50", period_lock); end
`ifdef LOCK_STATS_EN
        total++;
        if (relock_count !== 8'd4) begin bad++; $display("FAIL stats_enable_keep: got %0d want 4", relock_count); end
`endif
        enable = 1'b1;
        tick();
        gap(5);
        do_edge(50, 50);
        rst = 1'b1;
        tick();
        total++;
        if ({state, est_clear, est_hold, locked, lock_lost} !== 6'd0 || period_lock !== 16'd0) begin
            bad++; $display("FAIL ctrl_rst_acq: state=%0d clr=%b hold=%b lk=%b lost=%b per=%0d want all 0",
                            state, est_clear, est_hold, locked, lock_lost, period_lock);
        end
`ifdef LOCK_STATS_EN
        total++;
        if (relock_count !== 8'd0) begin bad++; $display("FAIL stats_rst: got %0d want 0", relock_count); end
`endif
        rst = 1'b0;
        tick();
    endtask

    initial begin
        test_reset();
        test_acquire();
        test_unstable();
        test_error_loss();
        test_leaky();
        test_timeout();
        test_control();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
